// File: rtl/timing_control_unit.sv
// rtl/timing_control_unit.sv - one-hot timing bus consumer: fetch/decode/execute sequencing and timing-sequence checker
module timing_control_unit #(
  parameter int T_WIDTH   = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic [T_WIDTH-1:0]   t_in,
  input  logic [15:0]          ir_in,
  input  logic                 start,
  output logic                 sc_clr,
  output logic [3:0]           t_idx,
  output logic                 fetch_ar,
  output logic                 fetch_ir,
  output logic                 decode,
  output logic                 indirect,
  output logic                 exec_en,
  output logic                 instr_done,
  output logic [CNT_WIDTH-1:0] icount,
  output logic                 seq_err,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           exp_idx_q, exp_idx_d;
  logic [2:0]           op_q, op_d;
  logic                 i_q, i_d;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] icount_q, icount_d;
  logic                 err_q, err_d;

  logic       t_valid;
  logic       seq_bad;
  logic       is_io;
  logic [3:0] last_step;
  logic       unused_ir;

  assign unused_ir = ^ir_in[11:0];

  // Lowest set bit wins so a multi-hot bus still yields a defined index.
  always_comb begin
    t_idx = 4'd0;
    for (int b = T_WIDTH - 1; b >= 0; b--) begin
      if (t_in[b]) t_idx = 4'(b);
    end
  end

  assign t_valid = $onehot(t_in);
  assign seq_bad = !t_valid || (t_idx != exp_idx_q);
  assign is_io   = (op_q == 3'd7);

  always_comb begin
    case (op_q)
      3'd7:       last_step = 4'd3;
      3'd3, 3'd4: last_step = 4'd4;
      3'd6:       last_step = 4'd6;
      default:    last_step = 4'd5;
    endcase
  end

  always_comb begin
    sc_clr   = 1'b0;
    fetch_ar = 1'b0;
    fetch_ir = 1'b0;
    decode   = 1'b0;
    indirect = 1'b0;
    exec_en  = 1'b0;
    case (state_q)
      S_FETCH: begin
        fetch_ar = t_in[0];
        fetch_ir = t_in[1];
        decode   = t_in[2];
      end
      S_EXEC: begin
        indirect = t_in[3] & i_q & !is_io;
        exec_en  = is_io ? t_in[3] : (t_idx >= 4'd4);
        sc_clr   = (t_idx == last_step);
      end
      default: sc_clr = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    exp_idx_d = exp_idx_q;
    op_d      = op_q;
    i_d       = i_q;
    done_d    = 1'b0;
    icount_d  = icount_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        exp_idx_d = 4'd0;
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        exp_idx_d = t_idx + 4'd1;
        if (seq_bad) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end else if (t_in[2]) begin
          // op_reg only becomes valid after this edge, hence decode reads ir_in.
          op_d    = ir_in[14:12];
          i_d     = ir_in[15];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        exp_idx_d = sc_clr ? 4'd0 : t_idx + 4'd1;
        if (seq_bad) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end else if (sc_clr) begin
          done_d   = 1'b1;
          icount_d = icount_q + 1'b1;
          state_d  = start ? S_FETCH : S_IDLE;
        end
      end
      default: err_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q   <= S_IDLE;
      exp_idx_q <= 4'd0;
      op_q      <= 3'd0;
      i_q       <= 1'b0;
      done_q    <= 1'b0;
      icount_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_idx_q <= exp_idx_d;
      op_q      <= op_d;
      i_q       <= i_d;
      done_q    <= done_d;
      icount_q  <= icount_d;
      err_q     <= err_d;
    end
  end

  assign instr_done = done_q;
  assign icount     = icount_q;
  assign seq_err    = err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_timing_control_unit.sv
// tb/tb_timing_control_unit.sv - randomized and directed bench for timing_control_unit against an instruction-level model
module tb_timing_control_unit;

  logic        CLK = 1'b0;
  logic        CLR;
  logic [15:0] t_in;
  logic [15:0] ir_in;
  logic        start;
  logic        sc_clr;
  logic [3:0]  t_idx;
  logic        fetch_ar, fetch_ir, decode, indirect, exec_en, instr_done;
  logic [7:0]  icount;
  logic        seq_err;
  logic [1:0]  state;

  timing_control_unit dut (
    .CLK(CLK), .CLR(CLR), .t_in(t_in), .ir_in(ir_in), .start(start),
    .sc_clr(sc_clr), .t_idx(t_idx), .fetch_ar(fetch_ar), .fetch_ir(fetch_ir),
    .decode(decode), .indirect(indirect), .exec_en(exec_en),
    .instr_done(instr_done), .icount(icount), .seq_err(seq_err), .state(state)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 fetch, 2 exec, 3 error; m_step counts cycles into the instruction.
  int last_of [8] = '{5, 5, 5, 4, 4, 5, 6, 3};
  int m_mode, m_step, m_op, m_cnt;
  bit m_i, m_done, m_err;
  bit e_clr, e_far, e_fir, e_dec, e_ind, e_ex;

  int sc;
  bit clr_prev;
  bit ign_clr;
  int skip_at;

  function automatic int lowest(input logic [15:0] v);
    for (int b = 0; b < 16; b++) if (v[b]) return b;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_step = 0; m_op = 0; m_i = 0; m_done = 0; m_cnt = 0; m_err = 0;
  endtask

  task automatic model_comb();
    int idx = lowest(t_in);
    e_clr = 0; e_far = 0; e_fir = 0; e_dec = 0; e_ind = 0; e_ex = 0;
    case (m_mode)
      1: begin e_far = t_in[0]; e_fir = t_in[1]; e_dec = t_in[2]; end
      2: begin
        e_ind = t_in[3] && m_i && (m_op != 7);
        e_ex  = (m_op == 7) ? t_in[3] : (idx >= 4);
        e_clr = (idx == last_of[m_op]);
      end
      default: e_clr = 1;
    endcase
  endtask

  task automatic model_edge();
    int idx = lowest(t_in);
    bit hot = ($countones(t_in) == 1);
    if (CLR) begin model_reset(); return; end
    m_done = 0;
    case (m_mode)
      0: begin m_step = 0; if (start) m_mode = 1; end
      1, 2: begin
        if (!hot || idx != m_step) begin
          m_mode = 3; m_err = 1;
        end else if (m_mode == 1) begin
          m_step++;
          if (idx == 2) begin m_op = ir_in[14:12]; m_i = ir_in[15]; m_mode = 2; end
        end else if (idx == last_of[m_op]) begin
          m_done = 1; m_cnt = (m_cnt + 1) % 256; m_step = 0; m_mode = start ? 1 : 0;
        end else begin
          m_step++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_all();
    model_comb();
    check("sc_clr", sc_clr, e_clr);
    check("fetch_ar", fetch_ar, e_far);
    check("fetch_ir", fetch_ir, e_fir);
    check("decode", decode, e_dec);
    check("indirect", indirect, e_ind);
    check("exec_en", exec_en, e_ex);
    check("t_idx", t_idx, lowest(t_in));
    check("state", state, m_mode);
    check("icount", icount, m_cnt);
    check("instr_done", instr_done, m_done);
    check("seq_err", seq_err, m_err);
  endtask

  // One clock: check at negedge, update model at posedge, advance sequencer 1ns later.
  task automatic cycle();
    @(negedge CLK);
    check_all();
    clr_prev = e_clr;
    @(posedge CLK);
    model_edge();
    #1;
    if (CLR || (clr_prev && !ign_clr)) sc = 0;
    else sc = (sc + 1) % 16;
    if (clr_prev && ign_clr) ign_clr = 0;
    if (sc == skip_at) begin sc = sc + 1; skip_at = -1; end
    t_in = 16'h1 << sc;
  endtask

  task automatic do_reset();
    CLR = 1;
    model_reset();
    cycle();
    cycle();
    CLR = 0;
    sc = 0; t_in = 16'h1; skip_at = -1; ign_clr = 0;
  endtask

  task automatic run_until_retire(input int max);
    int k = 0;
    do begin cycle(); k++; end while (!m_done && k < max);
    check("retire", instr_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    CLR = 1; start = 0; ir_in = 16'h0000; t_in = 16'h1;
    sc = 0; skip_at = -1; ign_clr = 0; clr_prev = 0;
    model_reset();
    do_reset();

    // Register/IO instruction, then straight into the next fetch.
    start = 1; ir_in = 16'h7800;
    run_until_retire(20);
    check("icount1", icount, 1);
    check("next_fetch", state, 1);
    check("next_t0", t_in, 16'h0001);

    // Indirect AND, then ISZ.
    ir_in = 16'h8000;
    run_until_retire(20);
    ir_in = 16'h6000;
    run_until_retire(20);
    check("icount3", icount, 3);

    // Asynchronous clear in the middle of EXEC at T4.
    ir_in = 16'h0000;
    for (int k = 0; k < 20 && !(m_mode == 2 && t_in == 16'h0010); k++) cycle();
    check("at_exec_t4", state, 2);
    CLR = 1;
    #1;
    model_reset();
    check_all();
    check("clr_state", state, 0);
    check("clr_icount", icount, 0);
    check("clr_sc_clr", sc_clr, 1);
    cycle(); cycle();
    CLR = 0; sc = 0; t_in = 16'h1;

    // Sequencer skips T2.
    do_reset();
    start = 1; ir_in = 16'h1000; skip_at = 2;
    repeat (8) cycle();
    check("skip_err", seq_err, 1);
    check("skip_state", state, 3);
    check("skip_clr", sc_clr, 1);

    // Two-hot timing bus in FETCH.
    do_reset();
    start = 1;
    cycle(); cycle();
    t_in = 16'h0003;
    repeat (5) cycle();
    check("dual_err", seq_err, 1);
    check("dual_state", state, 3);

    // Sequencer ignores sc_clr after STA.
    do_reset();
    start = 1; ir_in = 16'h3000; ign_clr = 1;
    repeat (10) cycle();
    check("ign_err", seq_err, 1);
    check("ign_state", state, 3);

    // Back-to-back BUN.
    do_reset();
    start = 1; ir_in = 16'h4000;
    repeat (5) run_until_retire(20);
    check("bun_icount", icount, 5);
    check("bun_err", seq_err, 0);

    // start drops during T1 of the third instruction.
    do_reset();
    start = 1; ir_in = 16'h1000;
    run_until_retire(20);
    run_until_retire(20);
    cycle();
    start = 0;
    run_until_retire(20);
    check("drop_state", state, 0);
    check("drop_clr", sc_clr, 1);
    check("drop_icount", icount, 3);

    // icount wrap after 256 retirements.
    do_reset();
    start = 1; ir_in = 16'h7800;
    repeat (256) run_until_retire(20);
    check("wrap_icount", icount, 0);

    // Random instructions, start toggles and occasional sequencer faults.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      ir_in = 16'($urandom);
      if ($urandom_range(0, 15) == 0) start = ~start;
      if ($urandom_range(0, 199) == 0) t_in = 16'($urandom);
      if ($urandom_range(0, 199) == 0) ign_clr = 1;
      if (m_mode == 3 && $urandom_range(0, 7) == 0) do_reset();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
